// File: rtl/joy_serial_pkg.sv
// Shared constants, slot-phase type and frame-length helper for the serial joystick reader.
package joy_serial_pkg;

    localparam int unsigned JOY_NUM_PLAYERS_DEF = 2;
    localparam int unsigned JOY_BITS_DEF        = 12;
    localparam int unsigned JOY_SKIP_DEF        = 1;
    localparam int unsigned JOY_CLK_DIV_DEF     = 16;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_SKIP,
        PH_SHIFT
    } joy_phase_e;

    // Slots per frame: one LOAD slot, the dummy slots, then every data bit.
    function automatic int unsigned joy_frame_slots(input int unsigned num_players,
                                                    input int unsigned bits_per_player,
                                                    input int unsigned skip_bits);
        return 1 + skip_bits + num_players * bits_per_player;
    endfunction

endpackage

// File: rtl/joy_clkgen.sv
// JOY_CLK generator: free-running divider, registered shift clock and a one-cycle
// enable on the clk12 cycle just before each JOY_CLK rising edge.
module joy_clkgen
    import joy_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = JOY_CLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_joy_clk,
    output logic o_rise_en
);

    localparam int unsigned DW = $clog2(CLK_DIV);

    logic [DW-1:0] r_div;
    logic          r_joy_clk;
    logic          w_wrap;

    assign w_wrap = (r_div == DW'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_joy_clk <= 1'b0;
        end else if (w_wrap) begin
            r_div     <= '0;
            r_joy_clk <= ~r_joy_clk;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign o_joy_clk = r_joy_clk;
    assign o_rise_en = w_wrap & ~r_joy_clk;

endmodule

// File: rtl/joy_serial_reader.sv
// Serial joystick chain reader with parametrised player count, width and header length.
// Optional frame debouncing is enabled by defining JOY_DEBOUNCE_EN.
module joy_serial_reader
    import joy_serial_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = JOY_NUM_PLAYERS_DEF,
    parameter int unsigned BITS_PER_PLAYER = JOY_BITS_DEF,
    parameter int unsigned SKIP_BITS       = JOY_SKIP_DEF,
    parameter int unsigned CLK_DIV         = JOY_CLK_DIV_DEF
) (
    input  logic                                   clk12,
    input  logic                                   reset,
    input  logic                                   JOY_DATA,
    output logic                                   JOY_CLK,
    output logic                                   JOY_LOAD,
    output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joy_out,
    output logic                                   frame_strobe
);

    localparam int unsigned W  = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int unsigned F  = joy_frame_slots(NUM_PLAYERS, BITS_PER_PLAYER, SKIP_BITS);
    localparam int unsigned SW = $clog2(F);

    logic          w_rise_en;
    logic          w_joy_clk;
    joy_phase_e    w_phase;
    logic [SW-1:0] w_idx;
    logic          w_last;

    logic [SW-1:0] r_slot;
    logic          r_run;
    logic          r_load;
    logic          r_done;
    logic          r_strobe;
    logic [1:0]    r_sync;
    logic [W-1:0]  r_shadow;
    logic [W-1:0]  r_joy;
`ifdef JOY_DEBOUNCE_EN
    logic [W-1:0]  r_prev;
`endif

    joy_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .i_clk    (clk12),
        .i_rst    (reset),
        .o_joy_clk(w_joy_clk),
        .o_rise_en(w_rise_en)
    );

    always_comb begin
        w_phase = PH_SHIFT;
        if (r_slot == '0) begin
            w_phase = PH_LOAD;
        end else if (r_slot <= SW'(SKIP_BITS)) begin
            w_phase = PH_SKIP;
        end
    end

    assign w_idx  = r_slot - SW'(1 + SKIP_BITS);
    assign w_last = (r_slot == SW'(F - 1));

    // r_run holds off slot advance so the first rise_en after reset opens slot 0.
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_slot   <= '0;
            r_run    <= 1'b0;
            r_load   <= 1'b1;
            r_done   <= 1'b0;
            r_sync   <= 2'b11;
            r_shadow <= '1;
        end else begin
            r_sync <= {r_sync[0], JOY_DATA};
            r_done <= 1'b0;
            if (w_rise_en) begin
                if (!r_run) begin
                    r_run  <= 1'b1;
                    r_slot <= '0;
                    r_load <= 1'b0;
                end else begin
                    if (w_phase == PH_SHIFT) begin
                        for (int k = 0; k < W; k++) begin
                            if (w_idx == SW'(k)) begin
                                r_shadow[k] <= r_sync[1];
                            end
                        end
                    end
                    if (w_last) begin
                        r_slot <= '0;
                        r_load <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_slot <= r_slot + SW'(1);
                        r_load <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            r_joy    <= '1;
            r_strobe <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
            r_prev   <= '1;
`endif
        end else begin
            r_strobe <= 1'b0;
            if (r_done) begin
`ifdef JOY_DEBOUNCE_EN
                r_prev <= r_shadow;
                if (r_shadow == r_prev) begin
                    r_joy    <= r_shadow;
                    r_strobe <= 1'b1;
                end
`else
                r_joy    <= r_shadow;
                r_strobe <= 1'b1;
`endif
            end
        end
    end

    assign JOY_CLK      = w_joy_clk;
    assign JOY_LOAD     = r_load;
    assign joy_out      = r_joy;
    assign frame_strobe = r_strobe;

endmodule

// File: doc/joy_serial_reader.md
# joy_serial_reader

Parametrised reader for the serial joystick/button chain behind the JAMMA adapter (daisy-chained parallel-in/serial-out shift registers driven by JOY_CLK/JOY_LOAD, read back on JOY_DATA). It generalises the fixed two-player, 24-bit, 26-slot reader used in arcade top levels to any player count, bits per player and header length. All logic runs on a single system clock with clock-enables, with no derived clocks. It sits in each core's top level; the top maps the flat active-low `joy_out` bus onto the core's joystick, coin and start inputs.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of player groups in the chain.
- BITS_PER_PLAYER, 12: bits per group.
- SKIP_BITS, 1: dummy slots between the LOAD slot and the first data bit.
- CLK_DIV, 16: clk12 cycles per JOY_CLK half-period. Must be ≥ 4.

Ports (W = NUM_PLAYERS*BITS_PER_PLAYER):
- clk12  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- JOY_DATA  in  1  serial data from the chain, asynchronous.
- JOY_CLK  out  1  chain shift clock, registered.
- JOY_LOAD  out  1  chain parallel-load, active-low, registered.
- joy_out  out  W  active-low button states (1 = released). Player p occupies [p*BITS_PER_PLAYER +: BITS_PER_PLAYER].
- frame_strobe  out  1  one-cycle pulse on the cycle `joy_out` is written.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. On wrap, JOY_CLK toggles.
- rise_en is the clk12 cycle where `div` wraps while JOY_CLK=0, so JOY_CLK goes high on the next edge.
- JOY_DATA passes through a 2-flop synchroniser. On rise_en the synchronised value is sampled.
- Slot counter `slot` runs 0..F-1, with F = 1+SKIP_BITS+W. It advances on each rise_en and wraps to 0 after F-1.
- States are derived from `slot`:
  - LOAD (slot 0): JOY_LOAD=0 for the whole slot.
  - SKIP (slots 1..SKIP_BITS): JOY_LOAD=1, sample discarded.
  - SHIFT (data slots): JOY_LOAD=1. On rise_en in slot 1+SKIP_BITS+k, the sample is written to shadow[k].
- The first bit shifted out lands in joy_out[0].
- On rise_en in slot F-1, the last bit is captured and the frame is complete. frame_strobe and the `joy_out` update follow per Configuration.
- Width rules:
  - `slot` width is $clog2(F).
  - `div` width is $clog2(CLK_DIV).
  - The shadow register is W bits, with no arithmetic on data.
- Reset, including mid-frame, returns to this state on the next edge:
  - div=0, slot=0, JOY_CLK=0, JOY_LOAD=1.
  - shadow all ones, joy_out all ones, frame_strobe=0.
  - Any partial frame is discarded.
- JOY_LOAD drops at the first rise_en after reset, i.e. when slot 0 begins.

## Timing
- JOY_CLK period is 2*CLK_DIV clk12 cycles. Frame period is F*2*CLK_DIV clk12 cycles. Defaults: F=26, period 832 cycles.
- JOY_LOAD transitions coincide with JOY_CLK rising edges: it falls entering slot 0 and rises entering slot 1.
- Sampling occurs CLK_DIV cycles after JOY_CLK falls. Synchroniser latency is 2 cycles, which is below CLK_DIV, so the data is settled.
- frame_strobe and `joy_out` update one cycle after the final rise_en, i.e. registered from the shadow.
- `joy_out` holds between strobes.

## Configuration
- JOY_DEBOUNCE_EN defined:
  - At frame end the completed shadow is compared with the previous completed frame `prev`.
  - If equal, joy_out<=shadow and frame_strobe pulses.
  - `prev` is always updated.
  - A change is therefore visible only after two identical consecutive frames.
  - `prev` resets to all ones.
- JOY_DEBOUNCE_EN undefined: every completed frame writes `joy_out` and pulses frame_strobe. No `prev` register exists.

## Structure
- Package joy_serial_pkg holds:
  - default parameter constants (JOY_NUM_PLAYERS_DEF, JOY_BITS_DEF, JOY_SKIP_DEF, JOY_CLK_DIV_DEF);
  - a slot-phase enum {PH_LOAD, PH_SKIP, PH_SHIFT};
  - a function returning F.
- Sub-module joy_clkgen holds the divider, JOY_CLK register and rise_en output. The parent holds the slot counter, synchroniser, shadow, debounce and outputs.

## Test plan
- Reset then free-run, defaults, chain model returning 24'h000000: slot 0 begins at the first rise_en. JOY_LOAD is low for exactly 32 cycles per 832-cycle frame. frame_strobe first pulses after frame 1 (undebounced) or frame 2 (debounced), and joy_out becomes 24'h000000.
- Chain pattern 24'hA5C3F0, shifted bit 0 first: joy_out==24'hA5C3F0. Player 1 bits [23:12]==12'hA5C.
- Reset asserted mid-SHIFT at slot 10, held 3 cycles: JOY_CLK=0, JOY_LOAD=1 and joy_out=24'hFFFFFF the cycle after. The next frame is complete and correct, with no partial data.
- JOY_DEBOUNCE_EN, frame sequence FFFFFF, 000001, FFFFFF, 000001, 000001: joy_out stays FFFFFF until the fifth frame, then becomes 000001.
- NUM_PLAYERS=4, BITS_PER_PLAYER=8, SKIP_BITS=2, CLK_DIV=4, pattern 32'h12345678: F=35, frame period 280 cycles, joy_out==32'h12345678.
- JOY_DATA toggled asynchronously relative to clk12: no X propagation, and the sample equals the level stable over the preceding 3 cycles.
